msj_pd_engine: RTL and testbench
================================

Name: msj_pd_engine

Overview:
- Time-multiplexed PD control engine serving NUM_CH motor channels with a single shared arithmetic datapath, replacing the per-channel controller instances.
- Sits between the angle-sensor interface (position/velocity plus per-channel update strobes) and the PWM generators (duty plus per-channel latch strobe).
- Adds setpoint slew limiting, a direct-duty mode, round-robin scheduling and sticky overrun flags.
- Has its own Avalon-MM register file.

Parameters:
- NUM_CH, 6, number of motor channels (1..255).
- DATA_W, 32, width of gains, setpoints, sensor inputs and duty (signed).
- SHIFT_W, 5, width of the per-channel output right-shift field.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  16  [15:8] register select, [7:0] channel.
- write  in  1  Avalon write.
- writedata  in  32  Avalon write data.
- read  in  1  Avalon read.
- readdata  out  32  Avalon read data.
- waitrequest  out  1  Avalon wait.
- position  in  NUM_CH*DATA_W  signed absolute angle per channel, channel c at [c*DATA_W +: DATA_W].
- velocity  in  NUM_CH*DATA_W  signed velocity per channel, same packing.
- update  in  NUM_CH  one-cycle strobe per channel: new sensor sample.
- duty  out  NUM_CH*DATA_W  signed duty per channel, held between updates.
- duty_valid  out  NUM_CH  one-cycle strobe when duty[c] changes; drives the PWM latch.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset: all duty = 0, duty_valid = 0, busy = 0, waitrequest = 1, readdata = 0, pending/overrun/last_err = 0.
- Register reset values per channel: Kp = 20, Kd = 10, sp = 0, mode = 0, shift = 6, posMax = 330, negMax = 300, deadBand = 0, slew = 0, sp_eff = 0.
- Register map (addr[15:8]), R/W unless noted:
  - 00 Kp; 01 Kd; 02 sp (target); 03 mode[1:0]; 04 posMax; 05 negMax; 06 deadBand; 07 shift[SHIFT_W-1:0]; 08 slew.
  - 09 sp_eff (RO); 0A duty (RO); 0B overrun (RO, any write to 0B clears that channel's flag).
- Write rules:
  - Writes complete in the cycle presented; waitrequest is 0 during write.
  - A write with channel >= NUM_CH or select > 0B is ignored.
- Read rules:
  - First read cycle has waitrequest = 1; next cycle waitrequest = 0 with readdata valid (1 wait state).
  - Channel out of range or unknown select returns 32'hDEADBEEF.
- Scheduling:
  - An update[c] pulse sets pending[c].
  - If pending[c] is already set, set overrun[c] (sticky); the strobe is coalesced.
  - In IDLE, grant the lowest pending channel at or after rr_ptr (wrapping), clear its pending bit, and set rr_ptr = grant+1 mod NUM_CH.
  - An update[c] in the same cycle c is granted leaves pending[c] set (no overrun).
- FSM: IDLE -> FETCH -> ERR -> MUL -> SCALE -> OUT -> IDLE, one cycle per state.
  - FETCH:
    - Latch all channel-c registers, position[c] and velocity[c].
    - Update sp_eff: if slew == 0, sp_eff = sp; otherwise step toward sp by at most slew, landing exactly on sp.
  - ERR:
    - err = sp_eff - position (mode 1) or sp_eff - velocity (mode 2).
    - derr = err - last_err[c]; last_err[c] <= err.
    - Width DATA_W+1.
  - MUL: p = Kp*err, d = Kd*derr, each 2*DATA_W+1 bits signed, registered.
  - SCALE:
    - u = (p+d) >>> shift (arithmetic shift).
    - If |err| <= deadBand, u = 0.
  - OUT:
    - Clamp u to [-negMax, +posMax] and write duty[c].
    - Pulse duty_valid[c].
    - Return to IDLE.
  - Other modes:
    - Mode 0 (off): duty 0, last_err cleared.
    - Mode 3 (direct): duty = clamp(sp_eff); Kp/Kd ignored.
  - All modes still traverse every state, giving fixed latency.
- Latency: with the FSM in IDLE, update[c] sampled at edge k gives duty_valid[c] high in the cycle following edge k+5.
  - Sustained throughput is one channel per 6 cycles.
  - Worst-case wait is 6*NUM_CH cycles.
- Register writes during an in-flight computation take effect at the next FETCH of that channel.
- A mode change to 0 takes effect at the next update.
- Reset asserted mid-computation: the FSM returns to IDLE immediately, no duty_valid is emitted, and all state takes reset values.

Test Plan:
- Reset, then read Kp ch0 (addr 0x0000) -> waitrequest 1 then 0, readdata 20. Read addr 0x0006 -> DEADBEEF.
- Mode 1 ch2, Kp=20, Kd=0, shift=0, sp=10, position=0, single update[2] -> duty[2]=200 and duty_valid[2] pulse 5 cycles later.
- Same setup but sp=100 -> duty[2]=330 (posMax clamp). Then sp=-100 -> duty[2]=-300 (negMax clamp).
- Kp=1, Kd=0, shift=0, slew=4, sp=10, position=0, three updates -> sp_eff 4, 8, 10; duty 4, 8, 10.
- All 6 channels in mode 1, update strobed on all channels in one cycle -> duty_valid pulses in order 0..5, 6 cycles apart, with no overrun. A second update[5] during ch0 processing -> overrun[5]=1. Write 0x0B05 -> overrun[5] reads 0.
- Reset asserted 3 cycles after a grant -> no duty_valid, duty all 0, busy 0 on the next cycle.

Source files
------------

// File: rtl/msj_pd_engine.sv
// msj_pd_engine
//   One arithmetic datapath runs a PD loop for NUM_CH motor channels in turn.
//   Each granted channel walks IDLE -> FETCH -> ERR -> MUL -> SCALE -> OUT.
//   Every mode takes the same path, so every computation has the same latency.
//   Per-channel configuration is held in an Avalon-MM register file.
//
// Ports
//   clock, reset       system clock, asynchronous active-high reset
//   address[15:0]      [15:8] register select, [7:0] channel
//   write, writedata   Avalon write (no wait states)
//   read, readdata     Avalon read (one wait state, registered data)
//   waitrequest        Avalon wait
//   position/velocity  packed signed sensor samples, channel c at [c*DATA_W +: DATA_W]
//   update[c]          new-sample strobe for channel c
//   duty               packed signed duty per channel, held between updates
//   duty_valid[c]      one-cycle strobe while duty[c] carries a fresh value
//   busy               engine is not idle
module msj_pd_engine #(
  parameter int NUM_CH  = 6,
  parameter int DATA_W  = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [15:0]              address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic                     read,
  output logic [31:0]              readdata,
  output logic                     waitrequest,
  input  logic [NUM_CH*DATA_W-1:0] position,
  input  logic [NUM_CH*DATA_W-1:0] velocity,
  input  logic [NUM_CH-1:0]        update,
  output logic [NUM_CH*DATA_W-1:0] duty,
  output logic [NUM_CH-1:0]        duty_valid,
  output logic                     busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW   = DATA_W + 1;      // error width
  localparam int PW   = 2 * DATA_W + 1;  // product width
  localparam int SW   = 2 * DATA_W + 2;  // sum width, cannot overflow
  localparam logic [8:0]      NCH9    = 9'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ERR, S_MUL, S_SCALE, S_OUT} state_t;

  // Clamp a wide result into [-lo_mag, +hi_lim].
  function automatic logic signed [DATA_W-1:0] sat_duty(
    input logic signed [SW-1:0]     v,
    input logic signed [DATA_W-1:0] hi_lim,
    input logic signed [DATA_W-1:0] lo_mag
  );
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = SW'(hi_lim);
    lo = -SW'(lo_mag);
    if (v > hi)      sat_duty = hi_lim;
    else if (v < lo) sat_duty = DATA_W'(lo);
    else             sat_duty = DATA_W'(v);
  endfunction

  // Move cur toward tgt by at most rate. The step lands exactly on tgt.
  // A zero rate jumps straight to tgt.
  function automatic logic signed [DATA_W-1:0] slew_step(
    input logic signed [DATA_W-1:0] cur,
    input logic signed [DATA_W-1:0] tgt,
    input logic signed [DATA_W-1:0] rate
  );
    logic signed [DATA_W+1:0] diff;
    logic signed [DATA_W+1:0] r;
    diff = (DATA_W+2)'(tgt) - (DATA_W+2)'(cur);
    r    = (DATA_W+2)'(rate);
    if (rate == '0)     slew_step = tgt;
    else if (diff > r)  slew_step = cur + rate;
    else if (diff < -r) slew_step = cur - rate;
    else                slew_step = tgt;
  endfunction

  // Register file
  logic signed [DATA_W-1:0] kp        [NUM_CH];
  logic signed [DATA_W-1:0] kd        [NUM_CH];
  logic signed [DATA_W-1:0] sp        [NUM_CH];
  logic        [1:0]        mode      [NUM_CH];
  logic signed [DATA_W-1:0] pos_max   [NUM_CH];
  logic signed [DATA_W-1:0] neg_max   [NUM_CH];
  logic signed [DATA_W-1:0] dead_band [NUM_CH];
  logic        [SHIFT_W-1:0] shift_amt [NUM_CH];
  logic signed [DATA_W-1:0] slew      [NUM_CH];
  logic signed [DATA_W-1:0] sp_eff    [NUM_CH];
  logic signed [DATA_W-1:0] duty_r    [NUM_CH];
  logic signed [EW-1:0]     last_err  [NUM_CH];
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH-1:0]        overrun;

  logic [7:0]      sel;
  logic [CH_W-1:0] bch;
  logic            ch_ok;
  logic            rd_ack;
  logic [31:0]     rd_mux;

  assign sel         = address[15:8];
  assign bch         = CH_W'(address[7:0]);
  assign ch_ok       = ({1'b0, address[7:0]} < NCH9);
  assign waitrequest = !(write || rd_ack);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        kp[c]        <= DATA_W'(20);
        kd[c]        <= DATA_W'(10);
        sp[c]        <= '0;
        mode[c]      <= '0;
        pos_max[c]   <= DATA_W'(330);
        neg_max[c]   <= DATA_W'(300);
        dead_band[c] <= '0;
        shift_amt[c] <= SHIFT_W'(6);
        slew[c]      <= '0;
      end
    end else if (write && ch_ok) begin
      case (sel)
        8'h00: kp[bch]        <= DATA_W'(writedata);
        8'h01: kd[bch]        <= DATA_W'(writedata);
        8'h02: sp[bch]        <= DATA_W'(writedata);
        8'h03: mode[bch]      <= writedata[1:0];
        8'h04: pos_max[bch]   <= DATA_W'(writedata);
        8'h05: neg_max[bch]   <= DATA_W'(writedata);
        8'h06: dead_band[bch] <= DATA_W'(writedata);
        8'h07: shift_amt[bch] <= writedata[SHIFT_W-1:0];
        8'h08: slew[bch]      <= DATA_W'(writedata);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'hDEADBEEF;
    if (ch_ok) begin
      case (sel)
        8'h00: rd_mux = 32'(kp[bch]);
        8'h01: rd_mux = 32'(kd[bch]);
        8'h02: rd_mux = 32'(sp[bch]);
        8'h03: rd_mux = 32'(mode[bch]);
        8'h04: rd_mux = 32'(pos_max[bch]);
        8'h05: rd_mux = 32'(neg_max[bch]);
        8'h06: rd_mux = 32'(dead_band[bch]);
        8'h07: rd_mux = 32'(shift_amt[bch]);
        8'h08: rd_mux = 32'(slew[bch]);
        8'h09: rd_mux = 32'(sp_eff[bch]);
        8'h0A: rd_mux = 32'(duty_r[bch]);
        8'h0B: rd_mux = 32'(overrun[bch]);
        default: ;
      endcase
    end
  end

  // Reads take one wait state. The first cycle captures the data. The second cycle presents it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ack   <= 1'b0;
      readdata <= '0;
    end else if (read && !rd_ack && !write) begin
      rd_ack   <= 1'b1;
      readdata <= rd_mux;
    end else begin
      rd_ack   <= 1'b0;
    end
  end

  // Scheduler
  state_t          state, state_next;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] gnt_ch;
  logic [CH_W-1:0] scan_idx;
  logic            gnt_found;
  logic            grant;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] ovr_nxt;

  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!gnt_found && pending[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = scan_idx;
      end
    end
  end

  assign grant = (state == S_IDLE) && gnt_found;

  // A strobe that lands on a channel whose request is being granted in the same cycle re-arms it cleanly.
  always_comb begin
    pend_nxt = pending;
    ovr_nxt  = overrun;
    if (grant) pend_nxt[gnt_ch] = 1'b0;
    if (write && ch_ok && sel == 8'h0B) ovr_nxt[bch] = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (update[c]) begin
        if (pending[c] && !(grant && gnt_ch == CH_W'(c))) ovr_nxt[c] = 1'b1;
        pend_nxt[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= pend_nxt;
      overrun <= ovr_nxt;
      if (grant) rr_ptr <= (gnt_ch == LAST_CH) ? '0 : gnt_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (gnt_found) state_next = S_FETCH;
      S_FETCH: state_next = S_ERR;
      S_ERR:   state_next = S_MUL;
      S_MUL:   state_next = S_SCALE;
      S_SCALE: state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Datapath
  logic [CH_W-1:0]          ch_p0;
  logic signed [DATA_W-1:0] kp_p1, kd_p1, pmax_p1, nmax_p1, db_p1, pos_p1, vel_p1, spe_p1;
  logic        [1:0]        mode_p1;
  logic        [SHIFT_W-1:0] shift_p1;
  logic signed [EW-1:0]     err_p2, derr_p2, err_p3;
  logic signed [PW-1:0]     p_p3, d_p3;

  logic signed [DATA_W-1:0] spe_nxt;
  logic signed [EW-1:0]     err_c;
  logic signed [SW-1:0]     sum_c, u_c;
  logic signed [DATA_W+1:0] err_ext, err_abs;
  logic                     in_db;
  logic signed [DATA_W-1:0] res_c;

  always_comb begin
    spe_nxt = slew_step(sp_eff[ch_p0], sp[ch_p0], slew[ch_p0]);
    case (mode_p1)
      2'd1:    err_c = EW'(spe_p1) - EW'(pos_p1);
      2'd2:    err_c = EW'(spe_p1) - EW'(vel_p1);
      default: err_c = '0;
    endcase
    sum_c   = SW'(p_p3) + SW'(d_p3);
    u_c     = sum_c >>> shift_p1;
    err_ext = (DATA_W+2)'(err_p3);
    err_abs = err_ext[DATA_W+1] ? -err_ext : err_ext;
    in_db   = (err_abs <= (DATA_W+2)'(db_p1));
    case (mode_p1)
      2'd0:    res_c = '0;
      2'd3:    res_c = sat_duty(SW'(spe_p1), pmax_p1, nmax_p1);
      default: res_c = in_db ? '0 : sat_duty(u_c, pmax_p1, nmax_p1);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_p0 <= '0;
      kp_p1 <= '0; kd_p1 <= '0; pmax_p1 <= '0; nmax_p1 <= '0; db_p1 <= '0;
      pos_p1 <= '0; vel_p1 <= '0; spe_p1 <= '0; mode_p1 <= '0; shift_p1 <= '0;
      err_p2 <= '0; derr_p2 <= '0; err_p3 <= '0; p_p3 <= '0; d_p3 <= '0;
      duty_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sp_eff[c]   <= '0;
        last_err[c] <= '0;
        duty_r[c]   <= '0;
      end
    end else begin
      duty_valid <= '0;
      case (state)
        // p0: grant
        S_IDLE: if (gnt_found) ch_p0 <= gnt_ch;
        // p1: snapshot config and sensors, advance slew-limited setpoint
        S_FETCH: begin
          kp_p1    <= kp[ch_p0];
          kd_p1    <= kd[ch_p0];
          mode_p1  <= mode[ch_p0];
          pmax_p1  <= pos_max[ch_p0];
          nmax_p1  <= neg_max[ch_p0];
          db_p1    <= dead_band[ch_p0];
          shift_p1 <= shift_amt[ch_p0];
          pos_p1   <= position[int'(ch_p0)*DATA_W +: DATA_W];
          vel_p1   <= velocity[int'(ch_p0)*DATA_W +: DATA_W];
          spe_p1   <= spe_nxt;
          sp_eff[ch_p0] <= spe_nxt;
        end
        // p2: error and derivative. The off and direct modes carry no error history.
        S_ERR: begin
          err_p2  <= err_c;
          derr_p2 <= err_c - last_err[ch_p0];
          last_err[ch_p0] <= (mode_p1 == 2'd1 || mode_p1 == 2'd2) ? err_c : '0;
        end
        // p3: products
        S_MUL: begin
          p_p3   <= PW'(kp_p1) * PW'(err_p2);
          d_p3   <= PW'(kd_p1) * PW'(derr_p2);
          err_p3 <= err_p2;
        end
        // p4: shift, dead band and clamp. Duty and its strobe become visible together during OUT.
        S_SCALE: begin
          duty_r[ch_p0]     <= res_c;
          duty_valid[ch_p0] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    duty = '0;
    for (int c = 0; c < NUM_CH; c++) duty[c*DATA_W +: DATA_W] = duty_r[c];
  end

endmodule

// File: tb/tb_msj_pd_engine.sv
// tb_msj_pd_engine
//   Directed and randomized bench for msj_pd_engine.
//   A behavioural per-channel model computes every expected duty with plain integer arithmetic.
module tb_msj_pd_engine;
  localparam int N = 6;
  localparam int W = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [15:0]     address = '0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic            read = 1'b0;
  logic [31:0]     readdata;
  logic            waitrequest;
  logic [N*W-1:0]  position = '0;
  logic [N*W-1:0]  velocity = '0;
  logic [N-1:0]    update = '0;
  logic [N*W-1:0]  duty;
  logic [N-1:0]    duty_valid;
  logic            busy;

  msj_pd_engine #(.NUM_CH(N), .DATA_W(W), .SHIFT_W(5)) dut (
    .clock(clock), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .position(position), .velocity(velocity),
    .update(update), .duty(duty), .duty_valid(duty_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nfail = 0;

  longint m_kp[N], m_kd[N], m_sp[N], m_mode[N], m_pmax[N], m_nmax[N];
  longint m_db[N], m_shift[N], m_slew[N], m_spe[N], m_lerr[N], m_duty[N];
  longint m_pos[N], m_vel[N];
  int     rr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_kp[c] = 20; m_kd[c] = 10; m_sp[c] = 0; m_mode[c] = 0; m_pmax[c] = 330;
      m_nmax[c] = 300; m_db[c] = 0; m_shift[c] = 6; m_slew[c] = 0; m_spe[c] = 0;
      m_lerr[c] = 0; m_duty[c] = 0;
    end
    rr = 0;
  endtask

  function automatic longint clampm(longint v, longint hi, longint lo);
    if (v > hi) return hi;
    if (v < -lo) return -lo;
    return v;
  endfunction

  // One channel computation at the level of the control law.
  task automatic model_step(input int ch, output longint d);
    longint err, derr, u, ae;
    if (m_slew[ch] == 0) m_spe[ch] = m_sp[ch];
    else if (m_sp[ch] - m_spe[ch] > m_slew[ch]) m_spe[ch] += m_slew[ch];
    else if (m_sp[ch] - m_spe[ch] < -m_slew[ch]) m_spe[ch] -= m_slew[ch];
    else m_spe[ch] = m_sp[ch];
    if (m_mode[ch] == 0) begin
      d = 0; m_lerr[ch] = 0;
    end else if (m_mode[ch] == 3) begin
      d = clampm(m_spe[ch], m_pmax[ch], m_nmax[ch]); m_lerr[ch] = 0;
    end else begin
      err  = m_spe[ch] - ((m_mode[ch] == 1) ? m_pos[ch] : m_vel[ch]);
      derr = err - m_lerr[ch];
      m_lerr[ch] = err;
      u  = (m_kp[ch] * err + m_kd[ch] * derr) >>> m_shift[ch];
      ae = (err < 0) ? -err : err;
      d  = (ae <= m_db[ch]) ? 0 : clampm(u, m_pmax[ch], m_nmax[ch]);
    end
    m_duty[ch] = d;
  endtask

  task automatic bus_write(input int sel, input int ch, input longint v);
    @(negedge clock);
    address = {8'(sel), 8'(ch)}; writedata = 32'(v); write = 1'b1;
    #1 chk("wr_wait", waitrequest, 0);
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic cfg(input int sel, input int ch, input longint v);
    bus_write(sel, ch, v);
    case (sel)
      0: m_kp[ch] = v;
      1: m_kd[ch] = v;
      2: m_sp[ch] = v;
      3: m_mode[ch] = v & 3;
      4: m_pmax[ch] = v;
      5: m_nmax[ch] = v;
      6: m_db[ch] = v;
      7: m_shift[ch] = v & 31;
      8: m_slew[ch] = v;
      default: ;
    endcase
  endtask

  task automatic bus_read(input int sel, input int ch, input string tag, output logic [31:0] data);
    @(negedge clock);
    address = {8'(sel), 8'(ch)}; read = 1'b1;
    #1 chk({tag, "_wait1"}, waitrequest, 1);
    @(negedge clock);
    chk({tag, "_wait0"}, waitrequest, 0);
    data = readdata;
    read = 1'b0;
  endtask

  task automatic set_inputs(input int ch, input longint p, input longint v);
    position[ch*W +: W] = 32'(p);
    velocity[ch*W +: W] = 32'(v);
    m_pos[ch] = p; m_vel[ch] = v;
  endtask

  task automatic upd_check(input int ch, input string tag);
    longint exp;
    int     cyc;
    bit     found;
    model_step(ch, exp);
    rr = (ch + 1) % N;
    @(negedge clock);
    update = N'(1 << ch);
    @(negedge clock);
    update = '0;
    cyc = 1; found = 1'b0;
    while (!found && cyc < 20) begin
      if (duty_valid != '0) found = 1'b1;
      else begin @(negedge clock); cyc++; end
    end
    chk({tag, "_seen"}, found, 1);
    chk({tag, "_lat"}, cyc, 6);
    chk({tag, "_vld"}, duty_valid, 1 << ch);
    chk({tag, "_duty"}, $signed(duty[ch*W +: W]), exp);
    @(negedge clock);
    chk({tag, "_vld_off"}, duty_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); @(negedge clock); reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] rd;
    longint      expd[N];
    int          order[N];
    logic [N-1:0] pend;
    int          cyc, np, ch, sel;
    longint      v, d;

    model_reset();
    @(negedge clock); @(negedge clock);
    chk("rst_duty", (duty == '0), 1);
    chk("rst_vld", duty_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait", waitrequest, 1);
    chk("rst_rdata", readdata, 0);
    reset = 1'b0;

    bus_read(8'h00, 0, "kp0", rd);       chk("kp0_val", rd, 20);
    bus_read(8'h00, 6, "ch6", rd);       chk("ch6_val", rd, 64'hDEADBEEF);
    bus_read(8'h0C, 0, "sel0c", rd);     chk("sel0c_val", rd, 64'hDEADBEEF);
    bus_read(8'h07, 3, "shift3", rd);    chk("shift3_val", rd, 6);
    bus_read(8'h05, 5, "negmax5", rd);   chk("negmax5_val", rd, 300);

    // proportional response and clamp limits on channel 2
    cfg(3, 2, 1); cfg(0, 2, 20); cfg(1, 2, 0); cfg(7, 2, 0); cfg(2, 2, 10);
    set_inputs(2, 0, 0);
    upd_check(2, "p200");
    cfg(2, 2, 100);  upd_check(2, "posclamp");
    cfg(2, 2, -100); upd_check(2, "negclamp");
    bus_read(8'h0A, 2, "duty2", rd);     chk("duty2_val", $signed(rd), m_duty[2]);

    // slew-limited setpoint on channel 1
    cfg(3, 1, 1); cfg(0, 1, 1); cfg(1, 1, 0); cfg(7, 1, 0); cfg(8, 1, 4); cfg(2, 1, 10);
    set_inputs(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      upd_check(1, "slew");
      bus_read(8'h09, 1, "spe1", rd);    chk("spe1_val", $signed(rd), m_spe[1]);
    end

    // all channels strobed together, plus a coalesced repeat on channel 5
    do_reset();
    for (int c = 0; c < N; c++) begin
      cfg(3, c, 1);
      cfg(0, c, $urandom_range(0, 30));
      cfg(1, c, $urandom_range(0, 30));
      cfg(7, c, $urandom_range(0, 3));
      cfg(4, c, $urandom_range(1000, 20000));
      cfg(5, c, $urandom_range(1000, 20000));
      cfg(2, c, longint'($urandom_range(0, 1000)) - 500);
      set_inputs(c, longint'($urandom_range(0, 1000)) - 500, 0);
    end
    pend = '1;
    for (int p = 0; p < N; p++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[(rr + i) % N]) begin order[p] = (rr + i) % N; break; end
      end
      pend[order[p]] = 1'b0;
      rr = (order[p] + 1) % N;
      model_step(order[p], d);
      expd[p] = d;
    end
    @(negedge clock); update = '1;
    @(negedge clock); update = '0;
    cyc = 1; np = 0;
    while (cyc <= 45) begin
      update = (cyc == 3) ? N'(1 << 5) : '0;
      if (duty_valid != '0) begin
        if (np < N) begin
          chk("batch_time", cyc, 6 * (np + 1));
          chk("batch_vld", duty_valid, 1 << order[np]);
          chk("batch_duty", $signed(duty[order[np]*W +: W]), expd[np]);
        end
        np++;
      end
      @(negedge clock); cyc++;
    end
    update = '0;
    chk("batch_count", np, N);
    bus_read(8'h0B, 5, "ovr5", rd);      chk("ovr5_set", rd, 1);
    bus_read(8'h0B, 0, "ovr0", rd);      chk("ovr0_clr", rd, 0);
    bus_read(8'h0B, 4, "ovr4", rd);      chk("ovr4_clr", rd, 0);
    bus_write(8'h0B, 5, 0);
    bus_read(8'h0B, 5, "ovr5b", rd);     chk("ovr5_cleared", rd, 0);

    // randomized configuration and sensor traffic
    for (int it = 0; it < 30; it++) begin
      ch = $urandom_range(0, N - 1);
      for (int k = 0; k < 3; k++) begin
        sel = $urandom_range(0, 8);
        case (sel)
          0, 1:    v = longint'($urandom_range(0, 40)) - 10;
          2:       v = longint'($urandom_range(0, 6000)) - 3000;
          3:       v = $urandom_range(0, 3);
          4, 5:    v = $urandom_range(50, 20000);
          6:       v = $urandom_range(0, 60);
          7:       v = $urandom_range(0, 6);
          default: v = $urandom_range(0, 400);
        endcase
        cfg(sel, ch, v);
      end
      set_inputs(ch, longint'($urandom_range(0, 6000)) - 3000, longint'($urandom_range(0, 6000)) - 3000);
      upd_check(ch, "rand");
      bus_read(8'h0A, ch, "rduty", rd);  chk("rand_duty_reg", $signed(rd), m_duty[ch]);
      bus_read(8'h09, ch, "rspe", rd);   chk("rand_spe_reg", $signed(rd), m_spe[ch]);
    end

    // reset during a computation
    cfg(3, 2, 1); cfg(0, 2, 20); cfg(1, 2, 0); cfg(7, 2, 0); cfg(2, 2, 10);
    cfg(4, 2, 330); cfg(5, 2, 300); cfg(6, 2, 0); cfg(8, 2, 0);
    set_inputs(2, 0, 0);
    upd_check(2, "pre_rst");
    @(negedge clock); update = N'(1 << 2);
    @(negedge clock); update = '0;
    @(negedge clock); @(negedge clock); @(negedge clock);
    chk("midrun_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_duty", (duty == '0), 1);
    chk("mrst_vld", duty_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (duty_valid != '0) np++;
    end
    chk("mrst_no_pulse", np, 0);
    chk("mrst_idle", busy, 0);
    bus_read(8'h00, 2, "kp2", rd);       chk("kp2_reset", rd, 20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
